// File: rtl/muldiv_pkg.sv
// muldiv_pkg: definitions shared by the multiply/divide unit and the control
// unit that issues to it.
//   - op codes carried on the 3-bit op bus (110/111 are reserved)
//   - state encoding for the iterative sequencer
//   - MD_ITERS, the number of shift steps spent in RUN
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  localparam logic [2:0] MD_MULTU = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational two's-complement negate-or-pass.
// It takes operand magnitudes at accept time and applies result sign
// correction in FIX.
//   W      : data width
//   value  : input word
//   negate : 1 -> result = -value, 0 -> result = value
//   result : corrected word
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit multiply/divide unit with architectural HI/LO.
// MULT/MULTU produce a 64-bit product, while DIV/DIVU produce a remainder in
// HI and a quotient in LO. Each iterative op runs 32 RUN cycles plus one FIX
// cycle. MTHI/MTLO write HI/LO directly from `a` in a single edge.
//   clk, rst : clock and synchronous active-high reset
//   a, b     : operands (a is also the MTHI/MTLO source)
//   op       : operation code (see muldiv_pkg)
//   start    : request, sampled only while idle
//   busy     : iterative op in flight (decoded from the state register)
//   done     : one-cycle pulse after HI/LO take a new iterative result
//   hi, lo   : HI/LO registers
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state, state_next;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   mag_b, raw_a;
  logic               op_div, neg_lo, neg_hi, div_zero;

  logic               accept, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_addend, mul_sum, div_diff;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed, rem_fixed;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign accept    = (state == ST_IDLE) && start &&
                     (op == MD_MULTU || op == MD_MULT ||
                      op == MD_DIVU  || op == MD_DIV);
  assign signed_op = op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign busy      = (state != ST_IDLE);

  muldiv_signfix #(.W(WIDTH)) u_mag_a (.value(a), .negate(a_neg), .result(a_mag));
  muldiv_signfix #(.W(WIDTH)) u_mag_b (.value(b), .negate(b_neg), .result(b_mag));

  // One iteration step. Multiply shifts the product right and adds the
  // multiplicand into the top half when the low bit is set. Divide shifts
  // remainder:quotient left and subtracts the divisor when it fits. The
  // shifted remainder always fits 32 bits, because before the last step the
  // remainder has absorbed at most 31 dividend bits. The borrow of the
  // 33-bit subtract therefore decides the quotient bit.
  always_comb begin
    mul_addend = acc[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}};
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_addend;
    div_diff   = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, mag_b};
    acc_step   = {mul_sum, acc[WIDTH-1:1]};
    if (op_div) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.value(acc), .negate(neg_lo), .result(prod_fixed));
  muldiv_signfix #(.W(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .negate(neg_lo), .result(quot_fixed));
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_hi), .result(rem_fixed));

  // Final HI/LO values. A zero divisor bypasses sign correction and reports
  // the dividend exactly as it was presented.
  always_comb begin
    fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
    fix_lo = prod_fixed[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = raw_a;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = rem_fixed;
        fix_lo = quot_fixed;
      end
    end
  end

  // Sequencer next state: IDLE -> RUN on accept, RUN for MD_ITERS steps,
  // then one FIX cycle back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (cnt == 5'(MD_ITERS - 1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath registers. HI/LO change only on an MTHI/MTLO edge in IDLE or
  // at the FIX edge, so they hold their old values throughout RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      op_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, a_mag};
            mag_b    <= b_mag;
            raw_a    <= a;
            op_div   <= op[1];
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= op[1] & (b == '0);
          end else if (start && op == MD_MTHI) begin
            hi <= a;
          end else if (start && op == MD_MTLO) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
        end
        ST_FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: directed self-checking bench for muldiv.
// Each scenario task drives its own stimulus and checks HI/LO, busy length
// and done pulses against hand-computed values.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one iterative op, scramble the inputs after the accept edge, and
  // count busy cycles plus done pulses until a few cycles past completion.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int busy_cycles, output int done_pulses);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
    busy_cycles = 0; done_pulses = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (done) done_pulses++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (done) done_pulses++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) tick();
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hi: got %h required 0", hi); end
    if (lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_lo: got %h required 0", lo); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mt_ops();
    op = MD_MTLO; a = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    start = 1'b0; a = 32'h0;
    tests_run += 4;
    if (lo !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL mtlo_lo: got %h required deadbeef", lo); end
    if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL mtlo_hi_kept: got %h required 0", hi); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mtlo_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL mtlo_done: got %b required 0", done); end
    op = MD_MTHI; a = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (hi !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL mthi_hi: got %h required 12345678", hi); end
    if (lo !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL mthi_lo_kept: got %h required deadbeef", lo); end
    op = 3'b110; a = 32'h5555_5555; b = 32'h3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reserved_busy: got %b required 0", busy); end
    if (hi !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL reserved_hi: got %h required 12345678", hi); end
    if (lo !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL reserved_lo: got %h required deadbeef", lo); end
  endtask

  task automatic test_multiply();
    vec_t v[6];
    int bc, dc;
    v[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    v[2] = '{MD_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    v[3] = '{MD_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    v[4] = '{MD_MULT,  32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_001E};
    v[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, bc, dc);
      tests_run += 4;
      if (hi !== v[i].hi) begin tests_failed++; $display("[TB] FAIL mul%0d_hi: got %h required %h", i, hi, v[i].hi); end
      if (lo !== v[i].lo) begin tests_failed++; $display("[TB] FAIL mul%0d_lo: got %h required %h", i, lo, v[i].lo); end
      if (bc !== 33) begin tests_failed++; $display("[TB] FAIL mul%0d_busy_cycles: got %0d required 33", i, bc); end
      if (dc !== 1) begin tests_failed++; $display("[TB] FAIL mul%0d_done_pulses: got %0d required 1", i, dc); end
    end
  endtask

  task automatic test_divide();
    vec_t v[7];
    int bc, dc;
    v[0] = '{MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[1] = '{MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    v[2] = '{MD_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
    v[3] = '{MD_DIVU, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    v[4] = '{MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    v[5] = '{MD_DIVU, 32'hFFFF_FFFF, 32'hC000_0000, 32'h3FFF_FFFF, 32'h0000_0001};
    v[6] = '{MD_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, bc, dc);
      tests_run += 4;
      if (hi !== v[i].hi) begin tests_failed++; $display("[TB] FAIL div%0d_hi: got %h required %h", i, hi, v[i].hi); end
      if (lo !== v[i].lo) begin tests_failed++; $display("[TB] FAIL div%0d_lo: got %h required %h", i, lo, v[i].lo); end
      if (bc !== 33) begin tests_failed++; $display("[TB] FAIL div%0d_busy_cycles: got %0d required 33", i, bc); end
      if (dc !== 1) begin tests_failed++; $display("[TB] FAIL div%0d_done_pulses: got %0d required 1", i, dc); end
    end
  endtask

  task automatic test_div_corner();
    vec_t v[3];
    int bc, dc;
    v[0] = '{MD_DIVU, 32'd100,       32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    v[1] = '{MD_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    v[2] = '{MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, bc, dc);
      tests_run += 3;
      if (hi !== v[i].hi) begin tests_failed++; $display("[TB] FAIL corner%0d_hi: got %h required %h", i, hi, v[i].hi); end
      if (lo !== v[i].lo) begin tests_failed++; $display("[TB] FAIL corner%0d_lo: got %h required %h", i, lo, v[i].lo); end
      if (bc !== 33) begin tests_failed++; $display("[TB] FAIL corner%0d_busy_cycles: got %0d required 33", i, bc); end
    end
  endtask

  task automatic test_start_ignored();
    int bc, dc;
    op = MD_MTHI; a = 32'h1111_1111; start = 1'b1;
    tick();
    op = MD_MTLO; a = 32'h2222_2222;
    tick();
    op = MD_MULTU; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0;
    bc = 0; dc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 10) begin
        tests_run += 2;
        if (hi !== 32'h1111_1111) begin tests_failed++; $display("[TB] FAIL run_hold_hi: got %h required 11111111", hi); end
        if (lo !== 32'h2222_2222) begin tests_failed++; $display("[TB] FAIL run_hold_lo: got %h required 22222222", lo); end
        op = MD_DIVU; a = 32'd1000; b = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) dc++;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) dc++;
      tick();
    end
    tests_run += 4;
    if (bc !== 33) begin tests_failed++; $display("[TB] FAIL ignored_busy_cycles: got %0d required 33", bc); end
    if (dc !== 1) begin tests_failed++; $display("[TB] FAIL ignored_done_pulses: got %0d required 1", dc); end
    if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL ignored_hi: got %h required 0", hi); end
    if (lo !== 32'd42) begin tests_failed++; $display("[TB] FAIL ignored_lo: got %h required 0000002a", lo); end
  endtask

  task automatic test_back_to_back();
    int bc;
    op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin bc++; tick(); end
    tests_run += 4;
    if (bc !== 33) begin tests_failed++; $display("[TB] FAIL b2b_first_busy_cycles: got %0d required 33", bc); end
    if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_done: got %b required 1", done); end
    if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL b2b_first_hi: got %h required 0", hi); end
    if (lo !== 32'd15) begin tests_failed++; $display("[TB] FAIL b2b_first_lo: got %h required 0000000f", lo); end
    op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 1;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second_accept: got busy %b required 1", busy); end
    bc = 0;
    while (busy && bc < 100) begin bc++; tick(); end
    tests_run += 3;
    if (bc !== 33) begin tests_failed++; $display("[TB] FAIL b2b_second_busy_cycles: got %0d required 33", bc); end
    if (hi !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL b2b_second_hi: got %h required ffffffff", hi); end
    if (lo !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL b2b_second_lo: got %h required fffffffa", lo); end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int seen_done, seen_busy;
    op = MD_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    tick();
    tests_run += 4;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b required 0", busy); end
    if (hi !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_hi: got %h required 0", hi); end
    if (lo !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_lo: got %h required 0", lo); end
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_done: got %b required 0", done); end
    rst = 1'b0;
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    tests_run += 2;
    if (seen_done !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d pulses required 0", seen_done); end
    if (seen_busy !== 0) begin tests_failed++; $display("[TB] FAIL abort_no_busy: got %0d cycles required 0", seen_busy); end
  endtask

  initial begin
    test_reset();
    test_mt_ops();
    test_multiply();
    test_divide();
    test_div_corner();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
